// File: rtl/nts_rx_buffer_pkg.sv
// Shared definitions for the NTS receive buffer: FSM state encoding, word geometry
// and the last-word byte-mask decoder.
package nts_rx_buffer_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COPY    = 3'd1,
        ST_DROP    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_READY   = 3'd4
    } state_t;

    // An all-zero mask means the whole last word is valid.
    function automatic logic [3:0] mask_to_bytes(input logic [7:0] mask);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            n = n + {3'd0, mask[i]};
        end
        return (n == 4'd0) ? 4'd8 : n;
    endfunction

endpackage

// File: rtl/nts_rx_buffer_ram.sv
// Simple dual-port 64-bit word RAM with a registered read port, shaped for block-RAM inference.
module nts_rx_buffer_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [63:0]           wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [63:0]           rd_data
);

    logic [63:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/nts_rx_buffer.sv
// Receive-side packet buffer: copies one packet from the dispatcher FIFO into local RAM,
// frees the dispatcher slot, then serves random-access word reads to the parser.
module nts_rx_buffer
    import nts_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    output logic                  o_busy,
    output logic                  o_error,
    input  logic                  i_dispatch_packet_available,
    output logic                  o_dispatch_packet_read_discard,
    input  logic [7:0]            i_dispatch_data_valid,
    input  logic                  i_dispatch_fifo_empty,
    output logic                  o_dispatch_fifo_rd_en,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_parser_packet_available,
    input  logic                  i_parser_packet_consumed,
    output logic [ADDR_WIDTH-1:0] o_parser_word_count,
    output logic [3:0]            o_parser_bytes_last_word,
    input  logic                  i_parser_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_parser_rd_addr,
    output logic                  o_parser_rd_valid,
    output logic [63:0]           o_parser_rd_data
);

    // Dispatcher FIFO handshake: asserting o_dispatch_fifo_rd_en pops one word, which
    // appears on i_dispatch_fifo_rd_data on the following cycle; i_dispatch_fifo_empty
    // reflects the FIFO after all previous pops. Parser reads return data exactly one
    // cycle after i_parser_rd_en, flagged by o_parser_rd_valid.

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   wr_addr;
    logic                  rd_en_d;
    logic                  err_flag;
    logic [ADDR_WIDTH-1:0] word_count;
    logic [3:0]            bytes_last_word;
    logic                  rd_valid;
    logic                  rd_gate;
    logic [63:0]           ram_rd_data;
    logic                  ram_we;
    logic                  drain_done;
    logic                  copy_stop;

    assign drain_done = i_dispatch_fifo_empty && !rd_en_d;
    assign ram_we     = (state == ST_COPY) && rd_en_d;

    // Stop popping once the words already stored plus the one in flight fill the RAM.
    assign copy_stop = wr_addr[ADDR_WIDTH] ||
                       (rd_en_d && (&wr_addr[ADDR_WIDTH-1:0]));

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full RAM counts as overrun even if the FIFO is empty: the word count port
    // cannot represent 2^ADDR_WIDTH words.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_dispatch_packet_available) begin
                    state_next = ST_COPY;
                end
            end
            ST_COPY: begin
                if (wr_addr[ADDR_WIDTH]) begin
                    state_next = ST_DROP;
                end else if (drain_done) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_DROP: begin
                if (drain_done) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = err_flag ? ST_IDLE : ST_READY;
            end
            ST_READY: begin
                if (i_parser_packet_consumed) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy                         = 1'b0;
        o_error                        = 1'b0;
        o_dispatch_packet_read_discard = 1'b0;
        o_dispatch_fifo_rd_en          = 1'b0;
        o_parser_packet_available      = 1'b0;
        case (state)
            ST_COPY: begin
                o_busy                = 1'b1;
                o_dispatch_fifo_rd_en = !i_dispatch_fifo_empty && !copy_stop;
            end
            ST_DROP: begin
                o_busy                = 1'b1;
                o_dispatch_fifo_rd_en = !i_dispatch_fifo_empty;
            end
            ST_RELEASE: begin
                o_busy                         = 1'b1;
                o_dispatch_packet_read_discard = 1'b1;
                o_error                        = err_flag;
            end
            ST_READY: begin
                o_parser_packet_available = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            wr_addr         <= '0;
            rd_en_d         <= 1'b0;
            err_flag        <= 1'b0;
            word_count      <= '0;
            bytes_last_word <= 4'd0;
            rd_valid        <= 1'b0;
            rd_gate         <= 1'b0;
        end else begin
            rd_en_d  <= o_dispatch_fifo_rd_en;
            rd_valid <= i_parser_rd_en;
            rd_gate  <= i_parser_rd_en && (state == ST_READY) &&
                        (i_parser_rd_addr < word_count);
            case (state)
                ST_IDLE: begin
                    wr_addr  <= '0;
                    err_flag <= 1'b0;
                end
                ST_COPY: begin
                    if (ram_we) begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                    if (!wr_addr[ADDR_WIDTH] && drain_done) begin
                        if (wr_addr == '0) begin
                            err_flag <= 1'b1;
                        end else begin
                            word_count      <= wr_addr[ADDR_WIDTH-1:0];
                            bytes_last_word <= mask_to_bytes(i_dispatch_data_valid);
                        end
                    end
                end
                ST_DROP: begin
                    if (drain_done) begin
                        err_flag <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (err_flag) begin
                        word_count      <= '0;
                        bytes_last_word <= 4'd0;
                    end
                end
                ST_READY: begin
                    if (i_parser_packet_consumed) begin
                        word_count      <= '0;
                        bytes_last_word <= 4'd0;
                        wr_addr         <= '0;
                    end
                end
                default: begin
                    wr_addr <= '0;
                end
            endcase
        end
    end

    nts_rx_buffer_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr[ADDR_WIDTH-1:0]),
        .wr_data (i_dispatch_fifo_rd_data),
        .rd_en   (i_parser_rd_en),
        .rd_addr (i_parser_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign o_parser_word_count      = word_count;
    assign o_parser_bytes_last_word = bytes_last_word;
    assign o_parser_rd_valid        = rd_valid;
    assign o_parser_rd_data         = rd_gate ? ram_rd_data : 64'd0;

endmodule

// File: tb/tb_nts_rx_buffer.sv
// Directed plus randomized bench for nts_rx_buffer with a queue-based dispatcher FIFO
// and a word-array model of the buffered packet.
module tb_nts_rx_buffer;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_areset;
    logic          o_busy;
    logic          o_error;
    logic          i_dispatch_packet_available;
    logic          o_dispatch_packet_read_discard;
    logic [7:0]    i_dispatch_data_valid;
    logic          i_dispatch_fifo_empty;
    logic          o_dispatch_fifo_rd_en;
    logic [63:0]   i_dispatch_fifo_rd_data;
    logic          o_parser_packet_available;
    logic          i_parser_packet_consumed;
    logic [AW-1:0] o_parser_word_count;
    logic [3:0]    o_parser_bytes_last_word;
    logic          i_parser_rd_en;
    logic [AW-1:0] i_parser_rd_addr;
    logic          o_parser_rd_valid;
    logic [63:0]   o_parser_rd_data;

    always #5 i_clk = ~i_clk;

    nts_rx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (i_clk),
        .i_areset                       (i_areset),
        .o_busy                         (o_busy),
        .o_error                        (o_error),
        .i_dispatch_packet_available    (i_dispatch_packet_available),
        .o_dispatch_packet_read_discard (o_dispatch_packet_read_discard),
        .i_dispatch_data_valid          (i_dispatch_data_valid),
        .i_dispatch_fifo_empty          (i_dispatch_fifo_empty),
        .o_dispatch_fifo_rd_en          (o_dispatch_fifo_rd_en),
        .i_dispatch_fifo_rd_data        (i_dispatch_fifo_rd_data),
        .o_parser_packet_available      (o_parser_packet_available),
        .i_parser_packet_consumed       (i_parser_packet_consumed),
        .o_parser_word_count            (o_parser_word_count),
        .o_parser_bytes_last_word       (o_parser_bytes_last_word),
        .i_parser_rd_en                 (i_parser_rd_en),
        .i_parser_rd_addr               (i_parser_rd_addr),
        .o_parser_rd_valid              (o_parser_rd_valid),
        .o_parser_rd_data               (o_parser_rd_data)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] fifo_q[$];
    logic [63:0] pkt[$];
    logic [63:0] buf_words[$];
    logic [63:0] exp_q[$];
    bit          ready_exp = 1'b0;
    int          pops, discards, errors, underflow;
    int          cur_n, cur_bytes, last_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT outputs mid-cycle, then act as dispatcher and parser after the edge.
    task automatic tick();
        logic s_rd, s_disc, s_err, s_prd;
        logic [63:0] e;
        @(negedge i_clk);
        s_rd   = o_dispatch_fifo_rd_en;
        s_disc = o_dispatch_packet_read_discard;
        s_err  = o_error;
        s_prd  = i_parser_rd_en;
        @(posedge i_clk);
        #1;
        i_parser_rd_en           = 1'b0;
        i_parser_packet_consumed = 1'b0;
        if (s_rd) begin
            pops++;
            if (fifo_q.size() > 0) i_dispatch_fifo_rd_data = fifo_q.pop_front();
            else underflow++;
        end
        if (s_disc) begin
            discards++;
            i_dispatch_packet_available = 1'b0;
        end
        if (s_err) errors++;
        i_dispatch_fifo_empty = (fifo_q.size() == 0);
        if (s_prd) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("rd_valid", {63'd0, o_parser_rd_valid}, 64'd1);
            chk("rd_data", o_parser_rd_data, e);
        end
    endtask

    // k = number of valid bytes in the last word, 0 meaning an all-zero mask (8 bytes).
    task automatic load(input int n, input int k);
        logic [7:0]  m;
        logic [63:0] w;
        m = 8'hFF;
        m = (k == 0) ? 8'h00 : (m << (8 - k));
        fifo_q.delete();
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            fifo_q.push_back(w);
            pkt.push_back(w);
        end
        pops = 0; discards = 0; errors = 0; underflow = 0;
        cur_n = n;
        cur_bytes = (k == 0) ? 8 : k;
        i_dispatch_data_valid       = m;
        i_dispatch_fifo_empty       = (n == 0);
        i_dispatch_packet_available = 1'b1;
    endtask

    task automatic finish_packet(input string tag);
        bit exp_err;
        int c;
        c = 0;
        while (discards == 0 && c < 2 * cur_n + 40) begin
            tick();
            c++;
        end
        last_lat = c;
        exp_err = (cur_n == 0) || (cur_n >= DEPTH);
        chk({tag, "_discard"}, discards, 1);
        chk({tag, "_error"}, errors, exp_err);
        chk({tag, "_pops"}, pops, cur_n);
        chk({tag, "_underflow"}, underflow, 0);
        chk({tag, "_avail"}, o_parser_packet_available, !exp_err);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_wc"}, o_parser_word_count, exp_err ? 0 : cur_n);
        if (!exp_err) chk({tag, "_bytes"}, o_parser_bytes_last_word, cur_bytes);
        tick();
        chk({tag, "_one_discard"}, discards, 1);
        chk({tag, "_one_error"}, errors, exp_err);
        ready_exp = !exp_err;
        buf_words = pkt;
    endtask

    task automatic prd(input int addr);
        i_parser_rd_en   = 1'b1;
        i_parser_rd_addr = addr[AW-1:0];
        exp_q.push_back((ready_exp && addr < buf_words.size()) ? buf_words[addr] : 64'd0);
        tick();
    endtask

    task automatic consume(input int addr);
        i_parser_packet_consumed = 1'b1;
        if (addr >= 0) begin
            i_parser_rd_en   = 1'b1;
            i_parser_rd_addr = addr[AW-1:0];
            exp_q.push_back((ready_exp && addr < buf_words.size()) ? buf_words[addr] : 64'd0);
        end
        tick();
        ready_exp = 1'b0;
        chk("consume_avail", o_parser_packet_available, 0);
        chk("consume_wc", o_parser_word_count, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_err"}, o_error, 0);
        chk({tag, "_disc"}, o_dispatch_packet_read_discard, 0);
        chk({tag, "_fifo_rd"}, o_dispatch_fifo_rd_en, 0);
        chk({tag, "_avail"}, o_parser_packet_available, 0);
        chk({tag, "_wc"}, o_parser_word_count, 0);
        chk({tag, "_bytes"}, o_parser_bytes_last_word, 0);
        chk({tag, "_rd_valid"}, o_parser_rd_valid, 0);
        chk({tag, "_rd_data"}, o_parser_rd_data, 0);
    endtask

    initial begin
        int n, k, c;
        i_areset = 1'b1;
        i_dispatch_packet_available = 1'b0;
        i_dispatch_data_valid = 8'h00;
        i_dispatch_fifo_empty = 1'b1;
        i_dispatch_fifo_rd_data = 64'd0;
        i_parser_packet_consumed = 1'b0;
        i_parser_rd_en = 1'b0;
        i_parser_rd_addr = '0;
        pops = 0; discards = 0; errors = 0; underflow = 0;
        repeat (3) tick();
        check_idle_outputs("reset");
        i_areset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // 5-word packet with four valid bytes in the last word
        load(5, 4);
        finish_packet("t1");
        chk("t1_latency_window", (last_lat >= 6 && last_lat <= 10), 1);

        for (int a = 0; a <= 5; a++) prd(a);
        tick();
        chk("rd_valid_idle", o_parser_rd_valid, 0);
        repeat (4) prd($urandom_range(0, 9));
        consume(-1);

        // Overrun: one word more than the buffer holds
        load(DEPTH + 1, $urandom_range(0, 8));
        finish_packet("t3");
        chk("t3_idle_busy", o_busy, 0);
        prd(0);

        // Empty packet
        load(0, 3);
        finish_packet("t4");
        prd(0);

        // Reset on the third popped word, then the packet is re-presented
        load(6, 2);
        c = 0;
        while (pops < 3 && c < 20) begin
            tick();
            c++;
        end
        chk("t5_reached_third_pop", pops, 3);
        i_areset = 1'b1;
        tick();
        check_idle_outputs("t5_reset");
        chk("t5_no_discard", discards, 0);
        i_areset = 1'b0;
        fifo_q = pkt;
        pops = 0; underflow = 0; errors = 0;
        i_dispatch_fifo_rd_data = 64'd0;
        i_dispatch_fifo_empty = 1'b0;
        finish_packet("t5");
        for (int a = 0; a <= 6; a++) prd(a);
        consume(-1);

        // Consume while a new packet is pending; read in the consume cycle still sees old data
        load(4, 5);
        finish_packet("t6a");
        load(7, 0);
        repeat (3) tick();
        chk("t6_ready_ignores_dispatch", pops, 0);
        chk("t6_still_ready", o_parser_packet_available, 1);
        consume(1);
        chk("t6_idle_busy", o_busy, 0);
        tick();
        chk("t6_copy_busy", o_busy, 1);
        finish_packet("t6b");
        for (int a = 0; a <= 7; a++) prd(a);
        consume(-1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 40);
            k = $urandom_range(0, 8);
            load(n, k);
            finish_packet("rand");
            for (int j = 0; j < 8; j++) prd($urandom_range(0, n + 3));
            consume((r % 2 == 0) ? $urandom_range(0, n - 1) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
